wb_write_decoder: RTL

//   Register-file write side, the counterpart of the read-port mux tree.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/decoder_n.sv | 18 +
 rtl/wb_write_decoder.sv | 70 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core package: register-file geometry and word types.
// Used by the writeback stage and its testbench.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;
  localparam int ZERO_REG   = 31;
  localparam int NREG       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xword_t;

endpackage

// File: rtl/decoder_n.sv
// Enabled one-hot decoder of an N-bit address.
// Ports: en, addr[N-1:0] in; onehot[2**N-1:0] out (all 0 when en=0).
module decoder_n #(
  parameter int N = 5
) (
  input  logic              en,
  input  logic [N-1:0]      addr,
  output logic [2**N-1:0]   onehot
);

  localparam int M = 2**N;

  always_comb begin
    onehot = '0;
    if (en) onehot = {{(M-1){1'b0}}, 1'b1} << addr;
  end

endmodule

// File: rtl/wb_write_decoder.sv
// Writeback stage: registers one RF write per cycle, decodes its
// destination to one-hot write enables, and flags forwarding hits.
// Ports: clk, reset (sync, high); in_valid/in_wr_en/in_addr/in_data
// request; stall, flush; rd_addr_a/b compare; out_we[NREG], out_data,
// out_valid, fwd_a_hit, fwd_b_hit.
module wb_write_decoder #(
  parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
  parameter int DATA_W   = cpu_pkg::XLEN,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_wr_en,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [2**ADDR_W-1:0] out_we,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 fwd_a_hit,
  output logic                 fwd_b_hit
);

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

  logic              valid;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Writes to the zero register are killed here, so neither the
  // decoder nor the forwarding compare needs its own zero check.
  logic load_we;
  assign load_we = in_valid & in_wr_en & (in_addr != ZADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      valid  <= 1'b0;
      we_q   <= 1'b0;
    end else if (!stall) begin
      valid  <= in_valid;
      we_q   <= load_we;
      addr_q <= in_addr;
      data_q <= in_data;
    end
  end

  decoder_n #(
    .N (ADDR_W)
  ) u_dec (
    .en     (we_q),
    .addr   (addr_q),
    .onehot (out_we)
  );

  assign out_data  = data_q;
  assign out_valid = valid;
  assign fwd_a_hit = we_q & (addr_q == rd_addr_a);
  assign fwd_b_hit = we_q & (addr_q == rd_addr_b);

endmodule
